// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the pipelined control unit.
// Holds the opcode values, the ALUo/mtr encodings, the control bundle layout,
// the bubble constant and the per-cycle pipeline action enum.
// Optional feature macro used by importers: CTRL_MULDIV_EN.
package ctrl_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMATH  = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [1:0] ALUO_ADD = 2'b00;
    localparam logic [1:0] ALUO_BR  = 2'b01;
    localparam logic [1:0] ALUO_R   = 2'b10;
    localparam logic [1:0] ALUO_I   = 2'b11;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;

    localparam int CTRL_W = 12;

    localparam int B_ALUO_HI = 11;
    localparam int B_ALUO_LO = 10;
    localparam int B_ALUS    = 9;
    localparam int B_BR      = 8;
    localparam int B_MR      = 7;
    localparam int B_MW      = 6;
    localparam int B_RW      = 5;
    localparam int B_MTR_HI  = 4;
    localparam int B_MTR_LO  = 3;
    localparam int B_J       = 2;
    localparam int B_JR      = 1;
    localparam int B_MD      = 0;

    // Field order matches the B_* bit positions above, MSB first.
    typedef struct packed {
        logic [1:0] aluo;
        logic       alus;
        logic       br;
        logic       mr;
        logic       mw;
        logic       rw;
        logic [1:0] mtr;
        logic       j;
        logic       jr;
        logic       md;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    typedef enum logic [2:0] {
        ACT_ADVANCE,
        ACT_FREEZE,
        ACT_MDHOLD,
        ACT_FLUSH,
        ACT_HAZARD
    } pipeAct_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational main decoder for the ID-stage instruction.
// Ports:
//   instr_i     ID instruction
//   ctrl_o      control bundle (all-zero for unrecognised opcodes)
//   illegal_o   opcode not recognised
//   rs1_used_o  instruction reads rs1
//   rs2_used_o  instruction reads rs2
// Optional feature: CTRL_MULDIV_EN sets md for R-type with funct7 = 0000001.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int ILEN = 32
) (
    input  logic [ILEN-1:0] instr_i,
    output ctrl_t           ctrl_o,
    output logic            illegal_o,
    output logic            rs1_used_o,
    output logic            rs2_used_o
);

    logic [6:0] opcode;
    logic [4:0] rd;
    logic       unusedBits;

    assign opcode     = instr_i[6:0];
    assign rd         = instr_i[11:7];
    assign unusedBits = ^instr_i[ILEN-1:12];

    // Opcode table. Everything starts cleared so unknown opcodes fall out as
    // an all-zero bundle; the rd == x0 override runs last so no case can
    // accidentally produce a write to the zero register.
    always_comb begin
        ctrl_o     = CTRL_BUBBLE;
        illegal_o  = 1'b0;
        rs1_used_o = 1'b0;
        rs2_used_o = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl_o.aluo = ALUO_R;
                ctrl_o.rw   = 1'b1;
                rs1_used_o  = 1'b1;
                rs2_used_o  = 1'b1;
`ifdef CTRL_MULDIV_EN
                if (instr_i[31:25] == F7_MULDIV) begin
                    ctrl_o.md = 1'b1;
                end
`endif
            end
            OP_LOAD: begin
                ctrl_o.alus = 1'b1;
                ctrl_o.mr   = 1'b1;
                ctrl_o.rw   = 1'b1;
                ctrl_o.mtr  = MTR_MEM;
                rs1_used_o  = 1'b1;
            end
            OP_IMATH, OP_LUI, OP_AUIPC: begin
                ctrl_o.aluo = ALUO_I;
                ctrl_o.alus = 1'b1;
                ctrl_o.rw   = 1'b1;
                rs1_used_o  = (opcode == OP_IMATH);
            end
            OP_STORE: begin
                ctrl_o.alus = 1'b1;
                ctrl_o.mw   = 1'b1;
                rs1_used_o  = 1'b1;
                rs2_used_o  = 1'b1;
            end
            OP_BRANCH: begin
                ctrl_o.aluo = ALUO_BR;
                ctrl_o.br   = 1'b1;
                rs1_used_o  = 1'b1;
                rs2_used_o  = 1'b1;
            end
            OP_JAL: begin
                ctrl_o.rw  = 1'b1;
                ctrl_o.j   = 1'b1;
                ctrl_o.mtr = MTR_PC4;
            end
            OP_JALR: begin
                ctrl_o.aluo = ALUO_ADD;
                ctrl_o.alus = 1'b1;
                ctrl_o.rw   = 1'b1;
                ctrl_o.jr   = 1'b1;
                ctrl_o.mtr  = MTR_PC4;
                rs1_used_o  = 1'b1;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
        if (rd == 5'd0) begin
            ctrl_o.rw = 1'b0;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined control unit. Decodes the ID instruction, carries the
// control bundle through ID/EX, EX/MEM and MEM/WB, inserts load-use bubbles,
// handles EX-resolved flushes and whole-pipe freezes.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   id_valid_i, id_instr_i  ID-stage instruction and its valid flag
//   ex_flush_i              branch/jump resolved in EX, kills the ID instruction
//   ext_stall_i             memory not ready, freezes every stage register
//   id_stall_o              hold PC and IF/ID this cycle
//   {ex,mem,wb}_valid_o     stage holds a live instruction
//   {ex,mem,wb}_ctrl_o      registered control bundle per stage
//   {ex,mem,wb}_rd_o        destination register per stage
//   ex_illegal_o            EX instruction had an unrecognised opcode
// Optional feature macro: CTRL_MULDIV_EN (multi-cycle divide/remainder hold).
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int ILEN          = 32,
    parameter int RAW           = 5,
    parameter int MULDIV_CYCLES = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [ILEN-1:0]   id_instr_i,
    input  logic              ex_flush_i,
    input  logic              ext_stall_i,
    output logic              id_stall_o,
    output logic              ex_valid_o,
    output logic              mem_valid_o,
    output logic              wb_valid_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic [CTRL_W-1:0] mem_ctrl_o,
    output logic [CTRL_W-1:0] wb_ctrl_o,
    output logic [RAW-1:0]    ex_rd_o,
    output logic [RAW-1:0]    mem_rd_o,
    output logic [RAW-1:0]    wb_rd_o,
    output logic              ex_illegal_o
);

    ctrl_t          idCtrl;
    logic           idIllegal;
    logic           rs1Used;
    logic           rs2Used;
    logic [RAW-1:0] idRd;
    logic [RAW-1:0] idRs1;
    logic [RAW-1:0] idRs2;

    logic           exValid_q, exValid_d;
    ctrl_t          exCtrl_q, exCtrl_d;
    logic [RAW-1:0] exRd_q, exRd_d;
    logic           exIllegal_q, exIllegal_d;
    logic           memValid_q, memValid_d;
    ctrl_t          memCtrl_q, memCtrl_d;
    logic [RAW-1:0] memRd_q, memRd_d;
    logic           wbValid_q, wbValid_d;
    ctrl_t          wbCtrl_q, wbCtrl_d;
    logic [RAW-1:0] wbRd_q, wbRd_d;

    logic           loadUse;
    logic           mdHold;
    logic           idStall;
    pipeAct_t       act;

    ctrl_decode #(.ILEN(ILEN)) uDecode (
        .instr_i    (id_instr_i),
        .ctrl_o     (idCtrl),
        .illegal_o  (idIllegal),
        .rs1_used_o (rs1Used),
        .rs2_used_o (rs2Used)
    );

    assign idRd  = id_instr_i[7 +: RAW];
    assign idRs1 = id_instr_i[15 +: RAW];
    assign idRs2 = id_instr_i[20 +: RAW];

    // A load in EX whose result the ID instruction needs cannot forward in
    // time; x0 is never a real dependency.
    assign loadUse = exValid_q & exCtrl_q.mr & (exRd_q != '0) & id_valid_i &
                     ((rs1Used & (idRs1 == exRd_q)) | (rs2Used & (idRs2 == exRd_q)));

`ifdef CTRL_MULDIV_EN
    localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
    logic [CNT_W-1:0] mdCnt_q, mdCnt_d;

    assign mdHold = (mdCnt_q != '0);
`else
    logic unusedCfg;

    assign unusedCfg = (MULDIV_CYCLES != 0);
    assign mdHold    = 1'b0;
`endif

    // Pick one action per cycle. The divide hold sits above flush because a
    // flush arriving mid-divide must not cut the divide short; the flush
    // source keeps asserting until the pipe moves again.
    always_comb begin
        act = ACT_ADVANCE;
        if (ext_stall_i) begin
            act = ACT_FREEZE;
        end else if (mdHold) begin
            act = ACT_MDHOLD;
        end else if (ex_flush_i) begin
            act = ACT_FLUSH;
        end else if (loadUse) begin
            act = ACT_HAZARD;
        end
    end

    // Next-state for all stage registers. Defaults hold everything, which is
    // exactly the freeze behaviour; the other actions shift stages and decide
    // what enters EX (decoded instruction or bubble).
    always_comb begin
        exValid_d   = exValid_q;
        exCtrl_d    = exCtrl_q;
        exRd_d      = exRd_q;
        exIllegal_d = exIllegal_q;
        memValid_d  = memValid_q;
        memCtrl_d   = memCtrl_q;
        memRd_d     = memRd_q;
        wbValid_d   = wbValid_q;
        wbCtrl_d    = wbCtrl_q;
        wbRd_d      = wbRd_q;
        idStall     = 1'b0;
`ifdef CTRL_MULDIV_EN
        mdCnt_d     = mdCnt_q;
`endif
        case (act)
            ACT_FREEZE: begin
                idStall = 1'b1;
            end
            ACT_MDHOLD: begin
                idStall    = 1'b1;
                wbValid_d  = memValid_q;
                wbCtrl_d   = memCtrl_q;
                wbRd_d     = memRd_q;
                memValid_d = 1'b0;
                memCtrl_d  = CTRL_BUBBLE;
                memRd_d    = '0;
`ifdef CTRL_MULDIV_EN
                mdCnt_d    = mdCnt_q - CNT_W'(1);
`endif
            end
            ACT_FLUSH, ACT_HAZARD: begin
                idStall     = (act == ACT_HAZARD);
                wbValid_d   = memValid_q;
                wbCtrl_d    = memCtrl_q;
                wbRd_d      = memRd_q;
                memValid_d  = exValid_q;
                memCtrl_d   = exCtrl_q;
                memRd_d     = exRd_q;
                exValid_d   = 1'b0;
                exCtrl_d    = CTRL_BUBBLE;
                exRd_d      = '0;
                exIllegal_d = 1'b0;
            end
            ACT_ADVANCE: begin
                wbValid_d   = memValid_q;
                wbCtrl_d    = memCtrl_q;
                wbRd_d      = memRd_q;
                memValid_d  = exValid_q;
                memCtrl_d   = exCtrl_q;
                memRd_d     = exRd_q;
                exValid_d   = id_valid_i;
                exCtrl_d    = id_valid_i ? idCtrl : CTRL_BUBBLE;
                exRd_d      = id_valid_i ? idRd : '0;
                exIllegal_d = id_valid_i & idIllegal;
`ifdef CTRL_MULDIV_EN
                if (id_valid_i && idCtrl.md && id_instr_i[14]) begin
                    mdCnt_d = CNT_W'(MULDIV_CYCLES - 1);
                end
`endif
            end
            default: begin
                idStall = 1'b0;
            end
        endcase
    end

    // Stage registers with synchronous reset; reset wins over every action.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exValid_q   <= 1'b0;
            exCtrl_q    <= CTRL_BUBBLE;
            exRd_q      <= '0;
            exIllegal_q <= 1'b0;
            memValid_q  <= 1'b0;
            memCtrl_q   <= CTRL_BUBBLE;
            memRd_q     <= '0;
            wbValid_q   <= 1'b0;
            wbCtrl_q    <= CTRL_BUBBLE;
            wbRd_q      <= '0;
        end else begin
            exValid_q   <= exValid_d;
            exCtrl_q    <= exCtrl_d;
            exRd_q      <= exRd_d;
            exIllegal_q <= exIllegal_d;
            memValid_q  <= memValid_d;
            memCtrl_q   <= memCtrl_d;
            memRd_q     <= memRd_d;
            wbValid_q   <= wbValid_d;
            wbCtrl_q    <= wbCtrl_d;
            wbRd_q      <= wbRd_d;
        end
    end

`ifdef CTRL_MULDIV_EN
    // Remaining extra EX cycles for the divide currently in EX.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mdCnt_q <= '0;
        end else begin
            mdCnt_q <= mdCnt_d;
        end
    end
`endif

    // The stall request is masked during reset so it reads 0 while the pipe
    // is being cleared, even if the memory side is also stalling.
    assign id_stall_o   = idStall & ~rst_i;
    assign ex_valid_o   = exValid_q;
    assign ex_ctrl_o    = exCtrl_q;
    assign ex_rd_o      = exRd_q;
    assign ex_illegal_o = exIllegal_q;
    assign mem_valid_o  = memValid_q;
    assign mem_ctrl_o   = memCtrl_q;
    assign mem_rd_o     = memRd_q;
    assign wb_valid_o   = wbValid_q;
    assign wb_ctrl_o    = wbCtrl_q;
    assign wb_rd_o      = wbRd_q;

endmodule
